// File: rtl/amm_nto1_arb_pkg.sv
// Shared helpers for the N-to-1 Avalon-MM arbiter.
package amm_nto1_arb_pkg;

    // Width of an index able to name any of n ports (at least 1 bit).
    function automatic int amm_idxw(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    // Pointer advance with wrap at an arbitrary depth.
    function automatic int amm_wrap_inc(input int v, input int depth);
        return (v == depth - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/amm_nto1_arb_rr_arbiter.sv
// One-hot grant generator: round-robin or fixed priority (port 0 highest).
// The pointer remembers the last granted port and only moves on a grant.
module amm_rr_arbiter
    import amm_nto1_arb_pkg::*;
#(
    parameter int P_N  = 4,
    parameter int P_RR = 1,
    localparam int IW  = amm_idxw(P_N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic [P_N-1:0] elig,
    output logic [P_N-1:0] gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [IW-1:0] ptr;

    // Pick the winner: RR searches upward from ptr+1 with wrap, FP takes the lowest index.
    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        if (en) begin
            if (P_RR != 0) begin
                for (int k = 1; k <= P_N; k++) begin
                    j = (int'(ptr) + k) % P_N;
                    if (!gnt_vld && elig[IW'(j)]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = IW'(j);
                    end
                end
            end else begin
                for (int i = P_N - 1; i >= 0; i--) begin
                    if (elig[i]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = IW'(i);
                    end
                end
            end
            if (gnt_vld) gnt[gnt_idx] = 1'b1;
        end
    end

    // Remember the last winner; reset so that port 0 is searched first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     ptr <= IW'(P_N - 1);
        else if (gnt_vld) ptr <= gnt_idx;
    end

endmodule

// File: rtl/amm_nto1_arb.sv
// N-to-1 Avalon-MM arbiter with registered master command and an index FIFO
// that routes pipelined read responses back to the issuing port in order.
module amm_nto1_arb
    import amm_nto1_arb_pkg::*;
#(
    parameter int P_NPORTS    = 4,
    parameter int P_AW        = 32,
    parameter int P_DW        = 32,
    parameter int P_LOG2OUTST = 2,
    parameter int P_RR        = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [P_NPORTS*P_AW-1:0]   s_address,
    input  logic [P_NPORTS*P_DW/8-1:0] s_byteenable,
    input  logic [P_NPORTS*P_DW-1:0]   s_writedata,
    input  logic [P_NPORTS-1:0]        s_read,
    input  logic [P_NPORTS-1:0]        s_write,
    output logic [P_NPORTS-1:0]        s_waitrequest,
    output logic [P_NPORTS*P_DW-1:0]   s_readdata,
    output logic [P_NPORTS-1:0]        s_readdatavalid,
    output logic [P_AW-1:0]            m_address,
    output logic [P_DW/8-1:0]          m_byteenable,
    output logic [P_DW-1:0]            m_writedata,
    output logic                       m_read,
    output logic                       m_write,
    input  logic                       m_waitrequest,
    input  logic [P_DW-1:0]            m_readdata,
    input  logic                       m_readdatavalid,
    output logic                       rsp_err
);

    localparam int BW    = P_DW / 8;
    localparam int IW    = amm_idxw(P_NPORTS);
    localparam int DEPTH = 1 << P_LOG2OUTST;
    localparam int PW    = (P_LOG2OUTST > 0) ? P_LOG2OUTST : 1;
    localparam int CW    = P_LOG2OUTST + 1;

    logic                ready;
    logic                slot_free;
    logic [P_NPORTS-1:0] elig;
    logic [P_NPORTS-1:0] gnt;
    logic [IW-1:0]       gnt_idx;
    logic                gnt_vld;

    logic [IW-1:0]       fifo_mem [DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic                fifo_full, push, pop;

    // Held low through reset so no port sees a grant until the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready <= 1'b0;
        else          ready <= 1'b1;
    end

    // Reads need a free tracking slot on the registered count; writes never wait on the FIFO.
    assign fifo_full = (count == CW'(DEPTH));
    assign elig      = s_write | (s_read & {P_NPORTS{~fifo_full}});
    assign slot_free = ready & (~(m_read | m_write) | ~m_waitrequest);

    amm_rr_arbiter #(.P_N(P_NPORTS), .P_RR(P_RR)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (slot_free),
        .elig    (elig),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign s_waitrequest = ~gnt;
    assign s_readdata    = {P_NPORTS{m_readdata}};

    // Load the granted command; idle the strobes when the slot frees without a winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_address    <= '0;
            m_byteenable <= '0;
            m_writedata  <= '0;
        end else if (slot_free) begin
            if (gnt_vld) begin
                m_address    <= s_address[gnt_idx*P_AW +: P_AW];
                m_byteenable <= s_byteenable[gnt_idx*BW +: BW];
                m_writedata  <= s_writedata[gnt_idx*P_DW +: P_DW];
                m_write      <= s_write[gnt_idx];
                m_read       <= ~s_write[gnt_idx];
            end else begin
                m_read  <= 1'b0;
                m_write <= 1'b0;
            end
        end
    end

    // A read grant records its port; a response pops only if something is outstanding.
    assign push = gnt_vld & ~s_write[gnt_idx];
    assign pop  = m_readdatavalid & (count != '0);

    // Index FIFO storage and pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= gnt_idx;
                wr_ptr           <= PW'(amm_wrap_inc(int'(wr_ptr), DEPTH));
            end
            if (pop) rd_ptr <= PW'(amm_wrap_inc(int'(rd_ptr), DEPTH));
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    // Route the response strobe to the port at the FIFO head.
    always_comb begin
        s_readdatavalid = '0;
        if (pop) s_readdatavalid[fifo_mem[rd_ptr]] = 1'b1;
    end

    // Sticky flag for a response nobody asked for.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                           rsp_err <= 1'b0;
        else if (m_readdatavalid && count == '0) rsp_err <= 1'b1;
    end

endmodule

// File: tb/tb_amm_nto1_arb.sv
// Directed bench for amm_nto1_arb: stimulus pushes expected master commands and
// read responses into queues; a negedge monitor pops and compares them.
module tb_amm_nto1_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N*AW-1:0]   s_address = '0;
    logic [N*DW/8-1:0] s_byteenable = '0;
    logic [N*DW-1:0]   s_writedata = '0;
    logic [N-1:0]      s_read = '0, s_write = '0;
    logic [N-1:0]      s_waitrequest, s_readdatavalid;
    logic [N*DW-1:0]   s_readdata;
    logic [AW-1:0]     m_address;
    logic [DW/8-1:0]   m_byteenable;
    logic [DW-1:0]     m_writedata;
    logic              m_read, m_write, rsp_err;
    logic              m_waitrequest = 1'b0;
    logic [DW-1:0]     m_readdata = '0;
    logic              m_readdatavalid = 1'b0;

    // fixed-priority instance sharing the same inputs
    logic [N-1:0]      fp_waitrequest, fp_readdatavalid;
    logic [N*DW-1:0]   fp_readdata;
    logic [AW-1:0]     fp_address;
    logic [DW/8-1:0]   fp_byteenable;
    logic [DW-1:0]     fp_writedata;
    logic              fp_read, fp_write, fp_rsp_err;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } cmd_t;
    typedef struct {
        int          port;
        logic [31:0] data;
    } rsp_t;

    cmd_t exp_cmd[$];
    rsp_t exp_rsp[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    amm_nto1_arb #(.P_NPORTS(N), .P_AW(AW), .P_DW(DW), .P_LOG2OUTST(2), .P_RR(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .m_address(m_address), .m_byteenable(m_byteenable), .m_writedata(m_writedata),
        .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .rsp_err(rsp_err)
    );

    amm_nto1_arb #(.P_NPORTS(N), .P_AW(AW), .P_DW(DW), .P_LOG2OUTST(2), .P_RR(0)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_read(s_read), .s_write(s_write), .s_waitrequest(fp_waitrequest),
        .s_readdata(fp_readdata), .s_readdatavalid(fp_readdatavalid),
        .m_address(fp_address), .m_byteenable(fp_byteenable), .m_writedata(fp_writedata),
        .m_read(fp_read), .m_write(fp_write), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .rsp_err(fp_rsp_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        s_address[p*AW +: AW]      = a;
        s_byteenable[p*4 +: 4]     = be;
        s_writedata[p*DW +: DW]    = d;
    endtask

    // One request from a single port, held until granted (bounded).
    task automatic issue(input int p, input bit wr, input logic [31:0] a, input logic [31:0] d);
        cmd_t c;
        int   n;
        c.wr = wr; c.addr = a; c.be = 4'hF; c.data = d;
        exp_cmd.push_back(c);
        set_port(p, a, 4'hF, d);
        s_read[p]  = !wr;
        s_write[p] = wr;
        n = 0;
        @(negedge clk);
        while (s_waitrequest[p] && n < 20) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("issue_gnt_p%0d", p), 64'(s_waitrequest[p]), 64'(0));
        tick();
        s_read[p]  = 1'b0;
        s_write[p] = 1'b0;
    endtask

    // One cycle of response data; the expected owner port is supplied by the caller.
    task automatic rdv(input int p, input logic [31:0] d);
        rsp_t r;
        r.port = p; r.data = d;
        exp_rsp.push_back(r);
        m_readdatavalid = 1'b1;
        m_readdata      = d;
        tick();
        m_readdatavalid = 1'b0;
    endtask

    // Monitor: compare every accepted master command and every routed response.
    always @(negedge clk) begin
        cmd_t c;
        rsp_t r;
        if (reset_n && (m_read || m_write) && !m_waitrequest) begin
            if (exp_cmd.size() == 0) begin
                check("cmd_unexpected", 64'({m_write, m_read}), 64'(0));
            end else begin
                c = exp_cmd.pop_front();
                check("cmd_kind", 64'({m_write, m_read}), 64'({c.wr, !c.wr}));
                check("cmd_addr", 64'(m_address), 64'(c.addr));
                check("cmd_be", 64'(m_byteenable), 64'(c.be));
                if (c.wr) check("cmd_data", 64'(m_writedata), 64'(c.data));
            end
        end
        if (s_readdatavalid != '0) begin
            if (exp_rsp.size() == 0) begin
                check("rsp_unexpected", 64'(s_readdatavalid), 64'(0));
            end else begin
                r = exp_rsp.pop_front();
                check("rsp_port", 64'(s_readdatavalid), 64'(4'b0001 << r.port));
                check("rsp_data", 64'(s_readdata[r.port*DW +: DW]), 64'(r.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c;
        logic [3:0] exp_wait;

        // 1: reset state, then release with no requests
        #23;
        check("t1_wait_rst", 64'(s_waitrequest), 64'(4'hF));
        check("t1_strobes_rst", 64'({m_read, m_write}), 64'(0));
        check("t1_err_rst", 64'(rsp_err), 64'(0));
        reset_n = 1'b1;
        #1;
        check("t1_wait_pre_edge", 64'(s_waitrequest), 64'(4'hF));
        tick();
        tick();
        check("t1_wait_idle", 64'(s_waitrequest), 64'(4'hF));
        check("t1_rdv_idle", 64'(s_readdatavalid), 64'(0));

        // 2: ports 0..2 write continuously; RR gives 0,1,2,0,1,2, FP gives port 0 only
        set_port(0, 32'h10, 4'hF, 32'hA000_0000);
        set_port(1, 32'h20, 4'h3, 32'hA000_0001);
        set_port(2, 32'h30, 4'hC, 32'hA000_0002);
        s_write = 4'b0111;
        for (int k = 0; k < 6; k++) begin
            c.wr   = 1'b1;
            c.addr = 32'h10 * (k % 3 + 1);
            c.be   = (k % 3 == 0) ? 4'hF : (k % 3 == 1) ? 4'h3 : 4'hC;
            c.data = 32'hA000_0000 + (k % 3);
            exp_cmd.push_back(c);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_wait = ~(4'b0001 << (k % 3));
            check("t2_rr_gnt", 64'(s_waitrequest), 64'(exp_wait));
            check("t2_fp_gnt", 64'(fp_waitrequest), 64'(4'b1110));
            tick();
        end
        s_write = '0;
        tick();

        // 3: port 3 read stalled downstream for 3 cycles, port 0 waits until release
        set_port(3, 32'h100, 4'hF, 32'h0);
        s_read[3] = 1'b1;
        c.wr = 1'b0; c.addr = 32'h100; c.be = 4'hF; c.data = '0;
        exp_cmd.push_back(c);
        @(negedge clk);
        check("t3_gnt3", 64'(s_waitrequest), 64'(4'b0111));
        tick();
        s_read[3]     = 1'b0;
        m_waitrequest = 1'b1;
        set_port(0, 32'h200, 4'hF, 32'h1234_5678);
        s_write[0] = 1'b1;
        c.wr = 1'b1; c.addr = 32'h200; c.be = 4'hF; c.data = 32'h1234_5678;
        exp_cmd.push_back(c);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_hold_addr", 64'(m_address), 64'(32'h100));
            check("t3_hold_read", 64'({m_read, m_write}), 64'(2'b10));
            check("t3_hold_wait", 64'(s_waitrequest), 64'(4'hF));
            tick();
        end
        m_waitrequest = 1'b0;
        @(negedge clk);
        check("t3_gnt0_after", 64'(s_waitrequest), 64'(4'b1110));
        tick();
        s_write[0] = 1'b0;
        rdv(3, 32'hD3D3_0003);

        // 4: two reads from port 1 then two from port 2; responses route 1,1,2,2
        issue(1, 1'b0, 32'h400, 32'h0);
        issue(1, 1'b0, 32'h404, 32'h0);
        issue(2, 1'b0, 32'h500, 32'h0);
        issue(2, 1'b0, 32'h504, 32'h0);
        rdv(1, 32'h1111_0000);
        rdv(1, 32'h1111_0001);
        rdv(2, 32'h2222_0000);
        rdv(2, 32'h2222_0001);
        tick();

        // 5: four reads outstanding block a fifth; a concurrent write still goes
        for (int k = 0; k < 4; k++) issue(0, 1'b0, 32'h600 + 4 * k, 32'h0);
        set_port(1, 32'h700, 4'hF, 32'h0);
        set_port(2, 32'h800, 4'hF, 32'h5555_AAAA);
        s_read[1]  = 1'b1;
        s_write[2] = 1'b1;
        c.wr = 1'b1; c.addr = 32'h800; c.be = 4'hF; c.data = 32'h5555_AAAA;
        exp_cmd.push_back(c);
        c.wr = 1'b0; c.addr = 32'h700; c.be = 4'hF; c.data = '0;
        exp_cmd.push_back(c);
        @(negedge clk);
        check("t5_write_passes", 64'(s_waitrequest), 64'(4'b1011));
        tick();
        s_write[2] = 1'b0;
        @(negedge clk);
        check("t5_read_full", 64'(s_waitrequest), 64'(4'hF));
        tick();
        begin
            rsp_t r;
            r.port = 0; r.data = 32'h0000_6000;
            exp_rsp.push_back(r);
        end
        m_readdatavalid = 1'b1;
        m_readdata      = 32'h0000_6000;
        @(negedge clk);
        check("t5_no_pop_credit", 64'(s_waitrequest), 64'(4'hF));
        tick();
        m_readdatavalid = 1'b0;
        @(negedge clk);
        check("t5_read_after_pop", 64'(s_waitrequest), 64'(4'b1101));
        tick();
        s_read[1] = 1'b0;
        rdv(0, 32'h0000_6001);
        rdv(0, 32'h0000_6002);
        rdv(0, 32'h0000_6003);
        rdv(1, 32'h0000_7000);
        tick();

        // 6: stray response sets sticky error; mid-burst reset clears count and flag
        m_readdatavalid = 1'b1;
        m_readdata      = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t6_stray_no_route", 64'(s_readdatavalid), 64'(0));
        tick();
        m_readdatavalid = 1'b0;
        check("t6_err_set", 64'(rsp_err), 64'(1));
        tick();
        tick();
        check("t6_err_sticky", 64'(rsp_err), 64'(1));
        issue(3, 1'b0, 32'h900, 32'h0);
        issue(3, 1'b0, 32'h904, 32'h0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_err", 64'(rsp_err), 64'(0));
        check("t6_rst_strobes", 64'({m_read, m_write}), 64'(0));
        check("t6_rst_wait", 64'(s_waitrequest), 64'(4'hF));
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        m_readdatavalid = 1'b1;
        m_readdata      = 32'h0BAD_0BAD;
        @(negedge clk);
        check("t6_count_cleared", 64'(s_readdatavalid), 64'(0));
        tick();
        m_readdatavalid = 1'b0;
        check("t6_err_again", 64'(rsp_err), 64'(1));

        tick();
        tick();
        check("end_cmd_queue", 64'(exp_cmd.size()), 64'(0));
        check("end_rsp_queue", 64'(exp_rsp.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
